// File: rtl/up_sampler_pkg.sv
// Shared FSM encoding and width helpers for the up_sampler_arbiter slice.
// Arbitration policy is chosen by UP_SAMPLER_ARB_ROUND_ROBIN_EN (see rr_arbiter).
package up_sampler_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int beat_width(input int i_factor);
        return (clog2(i_factor) < 1) ? 1 : clog2(i_factor);
    endfunction

    function automatic int tid_width(input int num_ch);
        return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
    endfunction

endpackage

// File: rtl/up_sampler_arbiter_rr.sv
// rr_arbiter: combinational one-hot grant and encoded index from a request vector.
// UP_SAMPLER_ARB_ROUND_ROBIN_EN defined: round-robin with registered pointer; else fixed priority.
module rr_arbiter
    import up_sampler_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = tid_width(NUM_CH)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              accept_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);

    logic [IDX_W-1:0] lowIdx;
    logic             lowAny;

    // Descending scan so the lowest requesting index is the one left standing.
    always_comb begin
        lowIdx = '0;
        lowAny = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                lowIdx = IDX_W'(k);
                lowAny = 1'b1;
            end
        end
    end

`ifdef UP_SAMPLER_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] highIdx;
    logic             highAny;

    // Requests at or above the pointer take precedence; otherwise wrap to the lowest one.
    always_comb begin
        highIdx = '0;
        highAny = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_i[k] && (IDX_W'(k) >= ptr_q)) begin
                highIdx = IDX_W'(k);
                highAny = 1'b1;
            end
        end
    end

    assign idx_o = highAny ? highIdx : lowIdx;
    assign ptr_d = (idx_o == IDX_W'(NUM_CH - 1)) ? '0 : idx_o + IDX_W'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unusedInputs;

    assign unusedInputs = aclk ^ aresetn ^ accept_i;
    assign idx_o        = lowIdx;
`endif

    assign any_o   = lowAny;
    assign grant_o = any_o ? (NUM_CH'(1) << idx_o) : '0;

endmodule

// File: rtl/up_sampler_arbiter.sv
// Shares one zero-insertion / zero-order-hold interpolator between NUM_CH AXI-Stream sources.
// Arbitration: UP_SAMPLER_ARB_ROUND_ROBIN_EN selects round-robin, otherwise fixed priority.
module up_sampler_arbiter
    import up_sampler_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int I_FACTOR        = 4,
    parameter int ZERO_ORDER_HOLD = 0,
    parameter int TDATA_WIDTH     = 8,
    parameter int TID_WIDTH       = tid_width(NUM_CH)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_CH-1:0]             s_axis_tvalid,
    output logic [NUM_CH-1:0]             s_axis_tready,
    input  logic [NUM_CH*TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
    output logic [TID_WIDTH-1:0]          m_axis_tid,
    output logic                          m_axis_tlast
);

    localparam int                BEAT_W    = beat_width(I_FACTOR);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(I_FACTOR - 1);

    state_e                 state_q;
    logic [BEAT_W-1:0]      beat_q;
    logic [BEAT_W-1:0]      beat_d;
    logic [TDATA_WIDTH-1:0] data_q;
    logic [TID_WIDTH-1:0]   tid_q;
    logic                   last_q;

    logic [NUM_CH-1:0]      grant;
    logic [TID_WIDTH-1:0]   winIdx;
    logic                   winAny;
    logic                   canAccept;
    logic                   accept;
    logic [TDATA_WIDTH-1:0] winData;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (TID_WIDTH)
    ) u_arb (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .req_i    (s_axis_tvalid),
        .accept_i (accept),
        .grant_o  (grant),
        .idx_o    (winIdx),
        .any_o    (winAny)
    );

    // A new sample may enter only when idle or as the final beat leaves.
    assign canAccept = aresetn &&
                       ((state_q == ST_IDLE) ||
                        ((state_q == ST_BURST) && last_q && m_axis_tready));
    assign accept        = canAccept && winAny;
    assign s_axis_tready = accept ? grant : '0;
    assign beat_d        = beat_q + BEAT_W'(1);

    always_comb begin
        winData = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (winIdx == TID_WIDTH'(k)) winData = s_axis_tdata[k*TDATA_WIDTH +: TDATA_WIDTH];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            data_q  <= '0;
            tid_q   <= '0;
            last_q  <= 1'b0;
        end else if (accept) begin
            state_q <= ST_BURST;
            beat_q  <= '0;
            data_q  <= winData;
            tid_q   <= winIdx;
            last_q  <= (I_FACTOR == 1);
        end else if ((state_q == ST_BURST) && m_axis_tready) begin
            if (ZERO_ORDER_HOLD == 0) data_q <= '0;
            if (last_q) begin
                state_q <= ST_IDLE;
                beat_q  <= '0;
                last_q  <= 1'b0;
            end else begin
                beat_q <= beat_d;
                last_q <= (beat_d == LAST_BEAT);
            end
        end
    end

    assign m_axis_tvalid = (state_q == ST_BURST);
    assign m_axis_tdata  = data_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tlast  = last_q;

endmodule

// File: tb/tb_up_sampler_arbiter.sv
// Bench for up_sampler_arbiter: three builds (I_FACTOR 4/4/1, hold 0/1/0) share one input stream.
// Expected arbitration follows UP_SAMPLER_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_up_sampler_arbiter;

    localparam int NCH  = 4;
    localparam int NDUT = 3;
    localparam int IFAC [NDUT] = '{4, 4, 1};
    localparam int HOLD [NDUT] = '{0, 1, 0};

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [NCH-1:0] sValid;
    logic [NCH*8-1:0] sData;
    logic           mReady;

    logic [NCH-1:0] sReady [NDUT];
    logic           mValid [NDUT];
    logic [7:0]     mData  [NDUT];
    logic [1:0]     mTid   [NDUT];
    logic           mLast  [NDUT];

    int checks = 0;
    int errors = 0;

    bit busyM   [NDUT];
    int beatM   [NDUT];
    int sampleM [NDUT];
    int tidM    [NDUT];
    int ptrM    [NDUT];

    always #5 aclk = ~aclk;

    up_sampler_arbiter #(.NUM_CH(4), .I_FACTOR(4), .ZERO_ORDER_HOLD(0), .TDATA_WIDTH(8)) dutZero (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(sValid), .s_axis_tready(sReady[0]), .s_axis_tdata(sData),
        .m_axis_tvalid(mValid[0]), .m_axis_tready(mReady), .m_axis_tdata(mData[0]),
        .m_axis_tid(mTid[0]), .m_axis_tlast(mLast[0])
    );

    up_sampler_arbiter #(.NUM_CH(4), .I_FACTOR(4), .ZERO_ORDER_HOLD(1), .TDATA_WIDTH(8)) dutHold (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(sValid), .s_axis_tready(sReady[1]), .s_axis_tdata(sData),
        .m_axis_tvalid(mValid[1]), .m_axis_tready(mReady), .m_axis_tdata(mData[1]),
        .m_axis_tid(mTid[1]), .m_axis_tlast(mLast[1])
    );

    up_sampler_arbiter #(.NUM_CH(4), .I_FACTOR(1), .ZERO_ORDER_HOLD(0), .TDATA_WIDTH(8)) dutOne (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(sValid), .s_axis_tready(sReady[2]), .s_axis_tdata(sData),
        .m_axis_tvalid(mValid[2]), .m_axis_tready(mReady), .m_axis_tdata(mData[2]),
        .m_axis_tid(mTid[2]), .m_axis_tlast(mLast[2])
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] valid, input logic [NCH*8-1:0] data,
                                 input logic ready);
        sValid = valid;
        sData  = data;
        mReady = ready;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Which channel the policy picks from a request set, -1 if none.
    function automatic int winner(input logic [NCH-1:0] v, input int start);
        for (int k = 0; k < NCH; k++) begin
`ifdef UP_SAMPLER_ARB_ROUND_ROBIN_EN
            int c = (start + k) % NCH;
`else
            int c = k + 0 * start;
`endif
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int d = 0; d < NDUT; d++) begin
            busyM[d]   = 1'b0;
            beatM[d]   = 0;
            sampleM[d] = 0;
            tidM[d]    = 0;
            ptrM[d]    = 0;
        end
    endtask

    // Model: a burst is "sample, beat index, owner"; each cycle the outputs follow from that.
    initial begin : compare
        modelReset();
        forever begin
            @(negedge aclk);
            if (!aresetn) modelReset();
            for (int d = 0; d < NDUT; d++) begin
                int w;
                int expReady;
                int expData;
                bit canAcc;
                w        = winner(sValid, ptrM[d]);
                canAcc   = aresetn && (!busyM[d] || ((beatM[d] == IFAC[d] - 1) && mReady));
                expReady = (canAcc && (w >= 0)) ? (1 << w) : 0;
                checkOutput($sformatf("dut%0d s_tready", d), int'(sReady[d]), expReady);
                checkOutput($sformatf("dut%0d m_tvalid", d), int'(mValid[d]), int'(busyM[d]));
                if (busyM[d]) begin
                    expData = ((beatM[d] == 0) || (HOLD[d] == 1)) ? sampleM[d] : 0;
                    checkOutput($sformatf("dut%0d m_tdata", d), int'(mData[d]), expData);
                    checkOutput($sformatf("dut%0d m_tid", d), int'(mTid[d]), tidM[d]);
                    checkOutput($sformatf("dut%0d m_tlast", d), int'(mLast[d]),
                                (beatM[d] == IFAC[d] - 1) ? 1 : 0);
                end
                if (aresetn) begin
                    if (busyM[d] && mReady) begin
                        if (beatM[d] < IFAC[d] - 1) beatM[d]++;
                        else busyM[d] = 1'b0;
                    end
                    if (canAcc && (w >= 0)) begin
                        busyM[d]   = 1'b1;
                        beatM[d]   = 0;
                        sampleM[d] = int'(sData[w*8 +: 8]);
                        tidM[d]    = w;
                        ptrM[d]    = (w + 1) % NCH;
                    end
                end
            end
        end
    end

    task automatic directedBurst(input int ch, input logic [7:0] val);
        logic [NCH-1:0]   vMask;
        logic [NCH*8-1:0] dat;
        vMask = '0;
        vMask[ch] = 1'b1;
        dat = '0;
        dat[ch*8 +: 8] = val;
        applyStimulus(vMask, dat, 1'b1);
        step();
        applyStimulus('0, '0, 1'b1);
        for (int b = 0; b < 4; b++) begin
            @(negedge aclk);
            checkOutput("zero-ins data", int'(mData[0]), (b == 0) ? int'(val) : 0);
            checkOutput("zero-ins tid", int'(mTid[0]), ch);
            checkOutput("zero-ins tlast", int'(mLast[0]), (b == 3) ? 1 : 0);
            checkOutput("hold data", int'(mData[1]), int'(val));
            checkOutput("hold tlast", int'(mLast[1]), (b == 3) ? 1 : 0);
            checkOutput("if1 tvalid", int'(mValid[2]), (b == 0) ? 1 : 0);
            if (b == 0) checkOutput("if1 tlast", int'(mLast[2]), 1);
            step();
        end
    endtask

    initial begin : stimulus
        logic [NCH*8-1:0] dat;
        int expTid;

        aresetn = 1'b0;
        applyStimulus(4'hF, 32'h44332211, 1'b1);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset tvalid", int'(mValid[0]), 0);
        checkOutput("reset tdata", int'(mData[0]), 0);
        checkOutput("reset tid", int'(mTid[0]), 0);
        checkOutput("reset tlast", int'(mLast[0]), 0);
        checkOutput("reset if1 tlast", int'(mLast[2]), 0);
        checkOutput("reset s_tready", int'(sReady[0]), 0);
        step();
        aresetn = 1'b1;

        // Every channel requesting, downstream always ready.
        step();
        for (int i = 0; i < 17; i++) begin
            @(negedge aclk);
            checkOutput("fair tvalid", int'(mValid[0]), 1);
            if (i % 4 == 0) begin
`ifdef UP_SAMPLER_ARB_ROUND_ROBIN_EN
                expTid = (i / 4) % NCH;
`else
                expTid = 0;
`endif
                checkOutput("fair tid", int'(mTid[0]), expTid);
            end
            step();
        end
        applyStimulus('0, '0, 1'b1);
        repeat (6) step();

        directedBurst(2, 8'h5A);
        directedBurst(0, 8'h11);

        // Stalls on a pattern of 1,0,0,1 while other channels keep requesting.
        applyStimulus(4'b0010, 32'h00004200, 1'b1);
        step();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'b1001, NCH*8'($urandom), ((i % 4) == 0) || ((i % 4) == 3));
            step();
        end
        applyStimulus('0, '0, 1'b1);
        repeat (8) step();

        // Reset after beat 1 has been handed off.
        applyStimulus(4'b0010, 32'h00003300, 1'b1);
        step();
        applyStimulus('0, '0, 1'b1);
        repeat (2) step();
        aresetn = 1'b0;
        @(negedge aclk);
        checkOutput("abort tvalid", int'(mValid[0]), 0);
        checkOutput("abort tdata", int'(mData[0]), 0);
        step();
        aresetn = 1'b1;
        applyStimulus(4'b1000, 32'h77000000, 1'b1);
        step();
        applyStimulus('0, '0, 1'b1);
        @(negedge aclk);
        checkOutput("restart data", int'(mData[0]), 8'h77);
        checkOutput("restart tid", int'(mTid[0]), 3);
        checkOutput("restart tlast", int'(mLast[0]), 0);
        step();
        @(negedge aclk);
        checkOutput("restart beat1", int'(mData[0]), 0);
        repeat (6) step();

        // I_FACTOR=1 build: ch1 and ch3 alternate, one tlast beat each.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                dat = '0;
                if (i % 2 == 0) begin
                    dat[15:8] = 8'h01;
                    applyStimulus(4'b0010, dat, 1'b1);
                end else begin
                    dat[31:24] = 8'h02;
                    applyStimulus(4'b1000, dat, 1'b1);
                end
            end else begin
                applyStimulus('0, '0, 1'b1);
            end
            @(negedge aclk);
            if (i > 0) begin
                checkOutput("if1 alt tvalid", int'(mValid[2]), 1);
                checkOutput("if1 alt data", int'(mData[2]), ((i - 1) % 2 == 0) ? 1 : 2);
                checkOutput("if1 alt tid", int'(mTid[2]), ((i - 1) % 2 == 0) ? 1 : 3);
                checkOutput("if1 alt tlast", int'(mLast[2]), 1);
            end
            step();
        end
        repeat (6) step();

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(NCH'($urandom_range(0, 15)), NCH*8'($urandom),
                          $urandom_range(0, 9) < 7);
            aresetn = ($urandom_range(0, 99) != 0);
            step();
        end
        aresetn = 1'b1;
        applyStimulus('0, '0, 1'b1);
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
